ascon_sequencer: RTL
====================

ASCON_SEQUENCER -- requirements
Module: ascon_sequencer

Interface
REQ-001 SHALL have these ports: clk input 1 (clock); nRST input 1 (reset, asynchronous, active-low).
REQ-002 SHALL have these inputs: start 1 (begin operation, sampled in IDLE); decrypt 1 (0=encrypt, 1=decrypt); ad_len 5 (AD bytes, 0-16); msg_len 5 (message bytes, 0-16); block_valid 1 (data block present); perm_done 1 (single-cycle pulse, permutation finished).
REQ-003 SHALL have these outputs: busy 1; perm_start 1 (single-cycle pulse); perm_rounds 4 (12 or 6, 0 otherwise); load_init 1 (load key/nonce/IV into state); key_xor 1 (XOR key into state); block_request 1; block_sel 1 (0=AD, 1=message); datalen 4 (valid bytes in current block, 0-8); dom_sep 1 (domain-separation pulse); dec_mode 1 (latched decrypt); done 1 (tag ready, single-cycle pulse).

Function
REQ-004 SHALL latch ad_len, msg_len and decrypt on the accepted start; later input changes SHALL have no effect until the next start.
REQ-005 SHALL ignore start while busy=1.
REQ-006 SHALL use states IDLE, INIT, INIT_WAIT, INIT_KEY, AD_REQ, AD_WAIT, DSEP, MSG_REQ, MSG_WAIT, FIN_KEY, FIN_WAIT, TAG.
REQ-007 SHALL transition IDLE->INIT on start; INIT pulses load_init and perm_start with perm_rounds=12, then goes to INIT_WAIT.
REQ-008 SHALL transition INIT_WAIT->INIT_KEY on perm_done; INIT_KEY pulses key_xor for one cycle, then goes to AD_REQ if ad_len!=0, else to DSEP.
REQ-009 SHALL use AD block count floor(ad_len/8)+1 when ad_len!=0; ad_len=16 gives 3 blocks, and the last block is padding only.
REQ-010 SHALL use message block count floor(msg_len/8)+1 always; msg_len=0 gives 1 padding-only block.
REQ-011 SHALL set datalen for block i (0-based) to min(8, len-8*i), with 0 for a padding-only block; datalen SHALL be 0 outside AD_REQ/MSG_REQ.
REQ-012 SHALL assert block_request continuously in AD_REQ/MSG_REQ; a block is accepted on any cycle with block_request=1 and block_valid=1; block_valid without block_request SHALL be ignored.
REQ-013 SHALL pulse perm_start with perm_rounds=6 in the acceptance cycle of every AD block, then go to AD_WAIT.
REQ-014 SHALL leave AD_WAIT on perm_done: to AD_REQ if AD blocks remain, else to DSEP.
REQ-015 SHALL make DSEP a single cycle with dom_sep=1, then go to MSG_REQ.
REQ-016 SHALL, on message-block acceptance: if not last, pulse perm_start with rounds=6 and go to MSG_WAIT; if last, go to FIN_KEY with no permutation.
REQ-017 SHALL return MSG_WAIT->MSG_REQ on perm_done.
REQ-018 SHALL make FIN_KEY pulse key_xor and perm_start with rounds=12, then go to FIN_WAIT.
REQ-019 SHALL go FIN_WAIT->TAG on perm_done; TAG pulses key_xor and done for one cycle, then goes to IDLE.
REQ-020 SHALL ignore perm_done outside the *_WAIT states; perm_done in the same cycle as perm_start SHALL be ignored.
REQ-021 SHALL keep busy=1 in every state except IDLE; done SHALL coincide with the last busy cycle.
REQ-022 SHALL hold block_sel at 0 in AD states and 1 in DSEP/MSG/FIN/TAG; dec_mode SHALL follow the latched decrypt.
REQ-023 SHALL saturate any ad_len/msg_len above 16 to 16.
REQ-024 SHALL keep the block counter 2 bits wide; it resets to 0 on entry to AD_REQ from INIT_KEY and on entry to MSG_REQ from DSEP.

Reset
REQ-025 SHALL, on nRST=0 at any time including mid-operation, go to IDLE immediately; all outputs 0, latched lengths 0, counters 0.
REQ-026 SHALL accept start on the first clock edge after nRST deasserts.

Verification
REQ-027 SHALL be verified: ad_len=0, msg_len=0, perm_done 3 cycles after each perm_start -> perm_rounds sequence 12,12; no AD request; one message request with datalen=0; dom_sep once; done once.
REQ-028 SHALL be verified: ad_len=16, msg_len=5 -> AD datalen 8,8,0 with three 6-round perms; message datalen 5, no message perm; final 12-round perm.
REQ-029 SHALL be verified: ad_len=3, msg_len=13, block_valid delayed 4 cycles per request -> block_request held until accepted; message datalen 8,5; exactly one 6-round message perm.
REQ-030 SHALL be verified: start pulsed during MSG_WAIT with different lengths -> ignored; the sequence completes with the original lengths.
REQ-031 SHALL be verified: nRST asserted in AD_WAIT -> all outputs 0 the same cycle; a new start after release runs a full correct sequence.
REQ-032 SHALL be verified: spurious perm_done in AD_REQ and in IDLE -> no state change, no perm_start.

Source files
------------

// File: rtl/ascon_sequencer.sv
// ascon_sequencer
// Control sequencer for an Ascon AEAD datapath. It walks one encrypt or
// decrypt operation through initialisation, associated-data absorption,
// domain separation, message processing and finalisation, driving the
// permutation core and requesting data blocks from the host side.
//
// Ports
//   clk, nRST      clock; asynchronous active-low reset
//   start          begin an operation (only honoured while idle)
//   decrypt        0 = encrypt, 1 = decrypt (latched on start)
//   ad_len         associated-data length in bytes, 0-16 (latched, saturated)
//   msg_len        message length in bytes, 0-16 (latched, saturated)
//   block_valid    host has the requested block available
//   perm_done      single-cycle pulse from the permutation core
//   busy           high in every state except IDLE
//   perm_start     single-cycle pulse launching a permutation
//   perm_rounds    round count for perm_start (12 or 6), 0 otherwise
//   load_init      load key/nonce/IV into the state
//   key_xor        XOR the key into the state
//   block_request  held high while waiting for an AD or message block
//   block_sel      0 = associated data, 1 = message
//   datalen        valid bytes of the requested block (0-8), 0 when not requesting
//   dom_sep        domain-separation pulse between AD and message
//   dec_mode       latched decrypt flag
//   done           tag ready, single-cycle pulse on the last busy cycle

module ascon_sequencer (
   input  logic       clk,
   input  logic       nRST,
   input  logic       start,
   input  logic       decrypt,
   input  logic [4:0] ad_len,
   input  logic [4:0] msg_len,
   input  logic       block_valid,
   input  logic       perm_done,
   output logic       busy,
   output logic       perm_start,
   output logic [3:0] perm_rounds,
   output logic       load_init,
   output logic       key_xor,
   output logic       block_request,
   output logic       block_sel,
   output logic [3:0] datalen,
   output logic       dom_sep,
   output logic       dec_mode,
   output logic       done
);

   localparam logic [3:0] ROUNDS_FULL = 4'd12;
   localparam logic [3:0] ROUNDS_HALF = 4'd6;

   typedef enum logic [3:0] {
      IDLE, INIT, INIT_WAIT, INIT_KEY, AD_REQ, AD_WAIT,
      DSEP, MSG_REQ, MSG_WAIT, FIN_KEY, FIN_WAIT, TAG
   } state_t;

   state_t     state;
   logic [4:0] ad_len_q;
   logic [4:0] msg_len_q;
   logic [1:0] blk_cnt;
   logic       perm_ok;

   // Lengths above 16 bytes are clamped to 16.
   function automatic logic [4:0] sat_len(input logic [4:0] len);
      return (len > 5'd16) ? 5'd16 : len;
   endfunction

   // Bytes carried by block idx: min(8, len - 8*idx). The block right after
   // the last full one is padding only and carries 0 bytes.
   function automatic logic [3:0] blk_bytes(input logic [4:0] len, input logic [1:0] idx);
      logic [4:0] rem;
      rem = len - {idx, 3'b000};
      return (rem > 5'd8) ? 4'd8 : rem[3:0];
   endfunction

   // A perm_done arriving together with our own perm_start cannot belong to
   // that permutation, so it is discarded.
   assign perm_ok = perm_done && !perm_start;

   // Single-process FSM. Every output is a register: each transition sets the
   // values the target state must present, and the one-cycle pulses default
   // low so they last exactly one cycle. The last block of a phase is the one
   // whose index equals floor(len/8), i.e. len[4:3].
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state         <= IDLE;
         ad_len_q      <= '0;
         msg_len_q     <= '0;
         blk_cnt       <= '0;
         busy          <= 1'b0;
         perm_start    <= 1'b0;
         perm_rounds   <= '0;
         load_init     <= 1'b0;
         key_xor       <= 1'b0;
         block_request <= 1'b0;
         block_sel     <= 1'b0;
         datalen       <= '0;
         dom_sep       <= 1'b0;
         dec_mode      <= 1'b0;
         done          <= 1'b0;
      end else begin
         perm_start  <= 1'b0;
         perm_rounds <= '0;
         load_init   <= 1'b0;
         key_xor     <= 1'b0;
         dom_sep     <= 1'b0;
         done        <= 1'b0;

         case (state)
            IDLE: begin
               if (start) begin
                  state       <= INIT;
                  ad_len_q    <= sat_len(ad_len);
                  msg_len_q   <= sat_len(msg_len);
                  dec_mode    <= decrypt;
                  busy        <= 1'b1;
                  block_sel   <= 1'b0;
                  load_init   <= 1'b1;
                  perm_start  <= 1'b1;
                  perm_rounds <= ROUNDS_FULL;
               end
            end

            INIT: state <= INIT_WAIT;

            INIT_WAIT: begin
               if (perm_ok) begin
                  state   <= INIT_KEY;
                  key_xor <= 1'b1;
               end
            end

            INIT_KEY: begin
               if (ad_len_q != 5'd0) begin
                  state         <= AD_REQ;
                  blk_cnt       <= 2'd0;
                  block_request <= 1'b1;
                  datalen       <= blk_bytes(ad_len_q, 2'd0);
               end else begin
                  state     <= DSEP;
                  block_sel <= 1'b1;
                  dom_sep   <= 1'b1;
               end
            end

            AD_REQ: begin
               if (block_valid) begin
                  state         <= AD_WAIT;
                  block_request <= 1'b0;
                  datalen       <= '0;
                  perm_start    <= 1'b1;
                  perm_rounds   <= ROUNDS_HALF;
               end
            end

            AD_WAIT: begin
               if (perm_ok) begin
                  if (blk_cnt != ad_len_q[4:3]) begin
                     state         <= AD_REQ;
                     blk_cnt       <= blk_cnt + 2'd1;
                     block_request <= 1'b1;
                     datalen       <= blk_bytes(ad_len_q, blk_cnt + 2'd1);
                  end else begin
                     state     <= DSEP;
                     block_sel <= 1'b1;
                     dom_sep   <= 1'b1;
                  end
               end
            end

            DSEP: begin
               state         <= MSG_REQ;
               blk_cnt       <= 2'd0;
               block_request <= 1'b1;
               datalen       <= blk_bytes(msg_len_q, 2'd0);
            end

            MSG_REQ: begin
               if (block_valid) begin
                  block_request <= 1'b0;
                  datalen       <= '0;
                  perm_start    <= 1'b1;
                  if (blk_cnt == msg_len_q[4:3]) begin
                     // The final block skips the 6-round permutation and goes
                     // straight into finalisation.
                     state       <= FIN_KEY;
                     key_xor     <= 1'b1;
                     perm_rounds <= ROUNDS_FULL;
                  end else begin
                     state       <= MSG_WAIT;
                     perm_rounds <= ROUNDS_HALF;
                  end
               end
            end

            MSG_WAIT: begin
               if (perm_ok) begin
                  state         <= MSG_REQ;
                  blk_cnt       <= blk_cnt + 2'd1;
                  block_request <= 1'b1;
                  datalen       <= blk_bytes(msg_len_q, blk_cnt + 2'd1);
               end
            end

            FIN_KEY: state <= FIN_WAIT;

            FIN_WAIT: begin
               if (perm_ok) begin
                  state   <= TAG;
                  key_xor <= 1'b1;
                  done    <= 1'b1;
               end
            end

            TAG: begin
               state     <= IDLE;
               busy      <= 1'b0;
               block_sel <= 1'b0;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
